// File: rtl/us_udp_rx_parser.sv
// UDP receive parser: strips the 8-byte UDP header, filters on the local port,
// trims the payload to the UDP length and reports header fields and drops.
module us_udp_rx_parser #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              rx_axis_aclk,
    input  logic              rx_axis_aresetn,
    input  logic [DATA_W-1:0] udp_rx_axis_tdata,
    input  logic [KEEP_W-1:0] udp_rx_axis_tkeep,
    input  logic              udp_rx_axis_tvalid,
    input  logic              udp_rx_axis_tuser,
    input  logic              udp_rx_axis_tlast,
    input  logic [31:0]       ip_mode_src_addr,
    input  logic [31:0]       ip_mode_dst_addr,
    input  logic [15:0]       local_udp_port,
    output logic [DATA_W-1:0] app_rx_axis_tdata,
    output logic [KEEP_W-1:0] app_rx_axis_tkeep,
    output logic              app_rx_axis_tvalid,
    output logic              app_rx_axis_tuser,
    output logic              app_rx_axis_tlast,
    output logic [15:0]       udp_src_port,
    output logic [15:0]       udp_dst_port,
    output logic [15:0]       udp_payload_len,
    output logic [31:0]       udp_src_ip,
    output logic              udp_hdr_valid,
    output logic [15:0]       udp_drop_cnt
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [15:0] remaining, remaining_nxt;
    logic        err_acc, err_acc_nxt;
    logic        drop_inc, hdr_accept;
    logic        out_vld, out_last, out_user;
    logic [KEEP_W-1:0] out_keep;
    logic [3:0]  beat_bytes;

    // Destination IP is carried on the interface but plays no part in port filtering.
    logic unused_dst_ip;
    assign unused_dst_ip = ^ip_mode_dst_addr;

    logic [15:0] hdr_src_p0, hdr_dst_p0, hdr_len_p0;
    assign hdr_src_p0 = {udp_rx_axis_tdata[7:0],   udp_rx_axis_tdata[15:8]};
    assign hdr_dst_p0 = {udp_rx_axis_tdata[23:16], udp_rx_axis_tdata[31:24]};
    assign hdr_len_p0 = {udp_rx_axis_tdata[39:32], udp_rx_axis_tdata[47:40]};

    function automatic logic [3:0] popcnt(input logic [KEEP_W-1:0] k);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < KEEP_W; i++) c = c + {3'b000, k[i]};
        return c;
    endfunction

    function automatic logic [KEEP_W-1:0] keep_mask(input logic [3:0] r);
        logic [8:0] t;
        t = (9'd1 << r) - 9'd1;
        return t[KEEP_W-1:0];
    endfunction

    assign beat_bytes = popcnt(udp_rx_axis_tkeep);

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        err_acc_nxt   = err_acc;
        drop_inc      = 1'b0;
        hdr_accept    = 1'b0;
        out_vld       = 1'b0;
        out_keep      = udp_rx_axis_tkeep;
        out_last      = 1'b0;
        out_user      = 1'b0;
        case (state)
            IDLE: begin
                if (udp_rx_axis_tvalid) begin
                    if (hdr_len_p0 < 16'd8 || hdr_dst_p0 != local_udp_port) begin
                        drop_inc = 1'b1;
                        if (!udp_rx_axis_tlast) state_nxt = DRAIN;
                    end else if (udp_rx_axis_tlast) begin
                        // Header-only segment is legal; anything longer was truncated upstream.
                        if (hdr_len_p0 == 16'd8) hdr_accept = 1'b1;
                        else                     drop_inc   = 1'b1;
                    end else begin
                        hdr_accept    = 1'b1;
                        remaining_nxt = hdr_len_p0 - 16'd8;
                        err_acc_nxt   = udp_rx_axis_tuser;
                        state_nxt     = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (udp_rx_axis_tvalid) begin
                    out_vld = 1'b1;
                    if (remaining <= {12'd0, beat_bytes}) begin
                        out_keep  = keep_mask(remaining[3:0]);
                        out_last  = 1'b1;
                        out_user  = err_acc | udp_rx_axis_tuser;
                        // Bytes past the UDP length are Ethernet padding.
                        state_nxt = udp_rx_axis_tlast ? IDLE : DRAIN;
                    end else if (udp_rx_axis_tlast) begin
                        out_last  = 1'b1;
                        out_user  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        remaining_nxt = remaining - {12'd0, beat_bytes};
                        err_acc_nxt   = err_acc | udp_rx_axis_tuser;
                    end
                end
            end
            DRAIN: begin
                if (udp_rx_axis_tvalid && udp_rx_axis_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register stage
    always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            state              <= IDLE;
            remaining          <= '0;
            err_acc            <= 1'b0;
            app_rx_axis_tdata  <= '0;
            app_rx_axis_tkeep  <= '0;
            app_rx_axis_tvalid <= 1'b0;
            app_rx_axis_tuser  <= 1'b0;
            app_rx_axis_tlast  <= 1'b0;
            udp_src_port       <= '0;
            udp_dst_port       <= '0;
            udp_payload_len    <= '0;
            udp_src_ip         <= '0;
            udp_hdr_valid      <= 1'b0;
            udp_drop_cnt       <= '0;
        end else begin
            state              <= state_nxt;
            remaining          <= remaining_nxt;
            err_acc            <= err_acc_nxt;
            app_rx_axis_tdata  <= udp_rx_axis_tdata;
            app_rx_axis_tkeep  <= out_vld ? out_keep : '0;
            app_rx_axis_tvalid <= out_vld;
            app_rx_axis_tuser  <= out_vld & out_user;
            app_rx_axis_tlast  <= out_vld & out_last;
            udp_hdr_valid      <= hdr_accept;
            udp_drop_cnt       <= udp_drop_cnt + {15'd0, drop_inc};
            if (hdr_accept) begin
                udp_src_port    <= hdr_src_p0;
                udp_dst_port    <= hdr_dst_p0;
                udp_payload_len <= hdr_len_p0 - 16'd8;
                udp_src_ip      <= ip_mode_src_addr;
            end
        end
    end

endmodule

// File: tb/tb_us_udp_rx_parser.sv
// Scoreboard bench for us_udp_rx_parser: directed packets push expected header
// and payload records; a monitor pops and compares whenever the DUT presents them.
module tb_us_udp_rx_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
    logic [31:0] src_ip = 32'hC0A8_0001, dst_ip = 32'hC0A8_0002;
    logic [15:0] local_port = 16'h1234;
    logic [63:0] a_data;
    logic [7:0]  a_keep;
    logic        a_valid, a_user, a_last;
    logic [15:0] o_src, o_dst, o_len, o_drop;
    logic [31:0] o_ip;
    logic        o_hv;

    us_udp_rx_parser dut (
        .rx_axis_aclk(clk), .rx_axis_aresetn(rst_n),
        .udp_rx_axis_tdata(tdata), .udp_rx_axis_tkeep(tkeep), .udp_rx_axis_tvalid(tvalid),
        .udp_rx_axis_tuser(tuser), .udp_rx_axis_tlast(tlast),
        .ip_mode_src_addr(src_ip), .ip_mode_dst_addr(dst_ip), .local_udp_port(local_port),
        .app_rx_axis_tdata(a_data), .app_rx_axis_tkeep(a_keep), .app_rx_axis_tvalid(a_valid),
        .app_rx_axis_tuser(a_user), .app_rx_axis_tlast(a_last),
        .udp_src_port(o_src), .udp_dst_port(o_dst), .udp_payload_len(o_len),
        .udp_src_ip(o_ip), .udp_hdr_valid(o_hv), .udp_drop_cnt(o_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [63:0] data; logic [7:0] keep; logic last; logic user; } app_t;
    typedef struct packed { logic [15:0] src; logic [15:0] dst; logic [15:0] len; logic [31:0] ip; } hdr_t;

    app_t app_q[$];
    hdr_t hdr_q[$];
    int   vecs = 0;
    int   errs = 0;
    logic [15:0] exp_drop = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        return {16'h0000, l[7:0], l[15:8], d[7:0], d[15:8], s[7:0], s[15:8]};
    endfunction

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic u, input logic l);
        tdata = d; tkeep = k; tuser = u; tlast = l; tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_app(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        app_q.push_back('{data: d, keep: k, last: l, user: u});
    endtask

    task automatic exp_hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        hdr_q.push_back('{src: s, dst: d, len: l, ip: src_ip});
    endtask

    task automatic chk_drop();
        gap(2);
        chk("drop_cnt", {80'd0, o_drop}, {80'd0, exp_drop});
    endtask

    task automatic monitor_step();
        app_t ea;
        hdr_t eh;
        @(negedge clk);
        if (rst_n) begin
            if (a_valid) begin
                if (app_q.size() == 0) begin
                    chk("unexpected_app_beat", {32'd0, a_data}, 96'd0);
                end else begin
                    ea = app_q.pop_front();
                    // tuser only carries meaning on the last beat
                    chk("app_beat", {22'd0, a_data, a_keep, a_last, a_last & a_user},
                        {22'd0, ea.data, ea.keep, ea.last, ea.last & ea.user});
                end
            end
            if (o_hv) begin
                if (hdr_q.size() == 0) begin
                    chk("unexpected_hdr_valid", {16'd0, o_src, o_dst, o_len, o_ip}, 96'd0);
                end else begin
                    eh = hdr_q.pop_front();
                    chk("hdr_fields", {16'd0, o_src, o_dst, o_len, o_ip},
                        {16'd0, eh.src, eh.dst, eh.len, eh.ip});
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {a_data[31:0], a_keep, a_valid, a_user, a_last, o_hv, o_src, o_dst, o_drop},
            96'd0);
        chk({name, "_b"}, {a_data[63:32], o_len, o_ip, 16'd0}, 96'd0);
    endtask

    task automatic stimulus();
        gap(3);
        chk_reset_outputs("reset_state");
        rst_n = 1'b1;
        gap(2);

        // Accepted packet, 12 payload bytes
        exp_hdr(16'h04D2, 16'h1234, 16'd12);
        beat(hdr(16'h04D2, 16'h1234, 16'h0014), 8'hFF, 0, 0);
        exp_app(64'h1111_2222_3333_4444, 8'hFF, 0, 0);
        beat(64'h1111_2222_3333_4444, 8'hFF, 0, 0);
        exp_app(64'h0000_0000_5555_6666, 8'h0F, 1, 0);
        beat(64'h0000_0000_5555_6666, 8'h0F, 0, 1);
        chk_drop();

        // Port mismatch, drained
        exp_drop++;
        beat(hdr(16'h1111, 16'h1235, 16'h0014), 8'hFF, 0, 0);
        beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 0);
        beat(64'hBBBB_BBBB_BBBB_BBBB, 8'h0F, 0, 1);
        chk_drop();

        // Padding trim: only 2 payload bytes valid, second beat discarded
        exp_hdr(16'h5000, 16'h1234, 16'd2);
        beat(hdr(16'h5000, 16'h1234, 16'h000A), 8'hFF, 0, 0);
        exp_app(64'h0102_0304_0506_0708, 8'h03, 1, 0);
        beat(64'h0102_0304_0506_0708, 8'hFF, 0, 0);
        beat(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 1);
        chk_drop();

        // Short packet: length claims 24 bytes, only 8 arrive
        exp_hdr(16'h0007, 16'h1234, 16'd24);
        beat(hdr(16'h0007, 16'h1234, 16'h0020), 8'hFF, 0, 0);
        exp_app(64'h7777_8888_9999_AAAA, 8'hFF, 1, 1);
        beat(64'h7777_8888_9999_AAAA, 8'hFF, 0, 1);
        chk_drop();

        // Correct length, upstream error on first payload beat
        exp_hdr(16'h0008, 16'h1234, 16'd16);
        beat(hdr(16'h0008, 16'h1234, 16'h0018), 8'hFF, 0, 0);
        exp_app(64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0);
        beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 1, 0);
        exp_app(64'h0FED_CBA9_8765_4321, 8'hFF, 1, 1);
        beat(64'h0FED_CBA9_8765_4321, 8'hFF, 0, 1);
        chk_drop();

        // Gaps inside a packet, then back-to-back second packet
        exp_hdr(16'h0009, 16'h1234, 16'd20);
        beat(hdr(16'h0009, 16'h1234, 16'h001C), 8'hFF, 0, 0);
        gap(1);
        exp_app(64'hC0C0_C0C0_C0C0_C0C0, 8'hFF, 0, 0);
        beat(64'hC0C0_C0C0_C0C0_C0C0, 8'hFF, 0, 0);
        gap(1);
        exp_app(64'hC1C1_C1C1_C1C1_C1C1, 8'hFF, 0, 0);
        beat(64'hC1C1_C1C1_C1C1_C1C1, 8'hFF, 0, 0);
        gap(2);
        exp_app(64'h0000_0000_C2C2_C2C2, 8'h0F, 1, 0);
        beat(64'h0000_0000_C2C2_C2C2, 8'h0F, 0, 1);
        exp_hdr(16'h000A, 16'h1234, 16'd8);
        beat(hdr(16'h000A, 16'h1234, 16'h0010), 8'hFF, 0, 0);
        exp_app(64'hD0D0_D0D0_D0D0_D0D0, 8'hFF, 1, 0);
        beat(64'hD0D0_D0D0_D0D0_D0D0, 8'hFF, 0, 1);
        chk_drop();

        // Header-only packet
        exp_hdr(16'h000B, 16'h1234, 16'd0);
        beat(hdr(16'h000B, 16'h1234, 16'h0008), 8'hFF, 0, 1);
        chk_drop();

        // Length below header size, multi-beat
        exp_drop++;
        beat(hdr(16'h000C, 16'h1234, 16'h0004), 8'hFF, 0, 0);
        beat(64'hEEEE_EEEE_EEEE_EEEE, 8'hFF, 0, 1);
        chk_drop();

        // Truncated: tlast on header while length says payload follows
        exp_drop++;
        beat(hdr(16'h000D, 16'h1234, 16'h0020), 8'hFF, 0, 1);
        chk_drop();

        // Reset mid-payload
        exp_hdr(16'h000E, 16'h1234, 16'd32);
        beat(hdr(16'h000E, 16'h1234, 16'h0028), 8'hFF, 0, 0);
        beat(64'hF0F0_F0F0_F0F0_F0F0, 8'hFF, 0, 0);
        chk("pre_reset_valid", {95'd0, a_valid}, 96'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        gap(2);
        rst_n = 1'b1;
        exp_drop = '0;
        gap(1);

        exp_hdr(16'h000F, 16'h1234, 16'd4);
        beat(hdr(16'h000F, 16'h1234, 16'h000C), 8'hFF, 0, 0);
        exp_app(64'h0000_0000_ABCD_EF01, 8'h0F, 1, 0);
        beat(64'h0000_0000_ABCD_EF01, 8'h0F, 0, 1);
        chk_drop();

        gap(4);
        chk("app_queue_empty", 96'(app_q.size()), 96'd0);
        chk("hdr_queue_empty", 96'(hdr_q.size()), 96'd0);
    endtask

    initial begin
        fork
            forever monitor_step();
            stimulus();
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
